subtractor_arbiter: RTL
=======================

Name: subtractor_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one subtractor_module instance between N_REQ KPN producer processes.
- Each requester presents an operand pair as a token.
- The arbiter grants one requester at a time and drives the shared subtractor's entry_1/entry_2.
- After a fixed latency it captures output_1, then returns the difference to the granted requester with an ack/result strobe.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 16, operand/result width (fixed-point word, passed through unchanged)
SUB_LATENCY, 1, cycles from operand application to valid subtractor output (1..15)
ID_W, 2, width of requester index; must equal clog2(N_REQ)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester token-available level
opa_bus  in  N_REQ*DATA_W  minuends; requester i occupies bits [i*DATA_W +: DATA_W]
opb_bus  in  N_REQ*DATA_W  subtrahends, same slicing
ack  out  N_REQ  one-hot, one-cycle pulse: token of requester i consumed
result  out  DATA_W  captured difference
result_valid  out  1  one-cycle pulse, coincident with ack
result_id  out  ID_W  index of requester owning result
busy  out  1  high in WAIT and DONE
sub_entry_1  out  DATA_W  to shared subtractor entry_1
sub_entry_2  out  DATA_W  to shared subtractor entry_2
sub_output_1  in  DATA_W  from shared subtractor output_1

Behaviour:
- Reset (sync, active-high, dominates everything): state=IDLE, rr_ptr=0, ack=0, result=0, result_valid=0, result_id=0, busy=0, sub_entry_1=0, sub_entry_2=0.
- FSM states: IDLE, WAIT, DONE.
- IDLE, no req bit set: remain in IDLE.
- IDLE, any req bit set at an edge:
  - Select the first set bit searching from rr_ptr upward, wrapping modulo N_REQ.
  - Register the selected index into result_id.
  - Register that requester's opa/opb slices into sub_entry_1/sub_entry_2.
  - Load wait counter with SUB_LATENCY; go to WAIT.
- WAIT: decrement counter each cycle. On the edge where counter==1:
  - Capture sub_output_1 into result.
  - Go to DONE.
  - WAIT therefore lasts exactly SUB_LATENCY cycles.
- DONE (exactly one cycle):
  - result_valid=1; ack[result_id]=1, all other ack bits 0.
  - Next state IDLE; rr_ptr <= (result_id+1) mod N_REQ.
- sub_entry_1/2 hold their values from grant until the next grant. They are not cleared in IDLE, so subtractor inputs stay stable.
- Latency: req sampled at edge k → ack/result_valid high during cycle after edge k+SUB_LATENCY+1. Issue rate is one operation per SUB_LATENCY+2 cycles.
- Handshake:
  - req is a level meaning "token present".
  - The requester must hold req and its operands stable until it sees ack.
  - req still high at the first IDLE edge after ack is treated as a new token. This is legal streaming.
- Requests are sampled only in IDLE. req changes or operand changes during WAIT/DONE do not affect the operation in flight; sub_entry values are registered copies.
- A req dropped mid-operation does not cancel; ack still pulses.
- Fairness:
  - A requester just served has lowest priority for the next grant.
  - With all req high, the grant order is 0,1,2,3,0,…
- Arithmetic: the arbiter performs none; result equals the subtractor output bit-for-bit. Wrap/sign follow the subtractor.
- Reset mid-operation: the in-flight operation is discarded, no ack is issued, rr_ptr returns to 0.
- Simultaneous reset and req: reset wins.
- busy=0 only in IDLE.

Test Plan:
- Single request, SUB_LATENCY=1: req=0001, opa0=0x0065, opb0=0x0047 → sub_entry_1=0x0065, sub_entry_2=0x0047 one cycle after sampling; result=0x001E, result_id=0, ack=0001, result_valid=1 exactly 2 cycles after the sampling edge, for 1 cycle.
- Round robin: req=1111 held. Operands requester i: opa=0x00C7, opb=0x0053+i → grant order 0,1,2,3,0. Results 0x0074, 0x0073, 0x0072, 0x0071. One ack every 3 cycles.
- Fairness after skip: rr_ptr=2 (after serving 1), req=0011 → requester 0 granted, then 1.
- Operand hold: after grant of opa=0x0C84/opb=0x0965, change opa0 to 0xFFFF during WAIT → result still 0x031F.
- Reset mid-operation: assert reset in WAIT → next cycle all outputs 0, no ack pulse. Subsequent req=0100 → requester 2 served normally.
- SUB_LATENCY=3: single request → ack exactly 4 cycles after sampling edge. busy high for 4 cycles.

Source files
------------

// File: rtl/subtractor_arbiter.sv
// Round-robin arbiter that time-shares one external subtractor among N_REQ
// token producers: grant, apply operands, wait SUB_LATENCY, return the difference.
module subtractor_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 16,
  parameter int SUB_LATENCY = 1,
  parameter int ID_W        = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] opa_bus,
  input  logic [N_REQ*DATA_W-1:0] opb_bus,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       result,
  output logic                    result_valid,
  output logic [ID_W-1:0]         result_id,
  output logic                    busy,
  output logic [DATA_W-1:0]       sub_entry_1,
  output logic [DATA_W-1:0]       sub_entry_2,
  input  logic [DATA_W-1:0]       sub_output_1
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic [ID_W-1:0]   result_id_q, result_id_d;
  logic [DATA_W-1:0] sub_entry_1_q, sub_entry_1_d;
  logic [DATA_W-1:0] sub_entry_2_q, sub_entry_2_d;
  logic [ID_W-1:0]   sel_idx;

  logic [DATA_W-1:0] opa_arr [N_REQ];
  logic [DATA_W-1:0] opb_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign opa_arr[i] = opa_bus[i*DATA_W +: DATA_W];
    assign opb_arr[i] = opb_bus[i*DATA_W +: DATA_W];
  end

  // Scan offsets high-to-low so the set bit closest to rr_ptr wins.
  always_comb begin : pick
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    sum     = '0;
    idx     = '0;
    sel_idx = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      sum = {1'b0, rr_ptr_q} + (ID_W+1)'(off);
      if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
      idx = sum[ID_W-1:0];
      if (req[idx]) sel_idx = idx;
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    cnt_d          = cnt_q;
    ack_d          = '0;
    result_d       = result_q;
    result_valid_d = 1'b0;
    result_id_d    = result_id_q;
    sub_entry_1_d  = sub_entry_1_q;
    sub_entry_2_d  = sub_entry_2_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          result_id_d   = sel_idx;
          sub_entry_1_d = opa_arr[sel_idx];
          sub_entry_2_d = opb_arr[sel_idx];
          cnt_d         = 4'(SUB_LATENCY);
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          result_d = sub_output_1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        // Strobes are registered, so they appear in the IDLE cycle that follows.
        ack_d[result_id_q] = 1'b1;
        result_valid_d     = 1'b1;
        rr_ptr_d = (result_id_q == ID_W'(N_REQ - 1)) ? '0 : result_id_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      cnt_q          <= '0;
      ack_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      result_id_q    <= '0;
      sub_entry_1_q  <= '0;
      sub_entry_2_q  <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
      ack_q          <= ack_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      result_id_q    <= result_id_d;
      sub_entry_1_q  <= sub_entry_1_d;
      sub_entry_2_q  <= sub_entry_2_d;
    end
  end

  assign ack          = ack_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign result_id    = result_id_q;
  assign busy         = (state_q != S_IDLE);
  assign sub_entry_1  = sub_entry_1_q;
  assign sub_entry_2  = sub_entry_2_q;

endmodule
